// File: rtl/limn2600_bus_timer.sv
// limn2600_bus_timer: memory-mapped interval timer on the Limn2600 CPU bus.
// A two-state bus responder (IDLE/ACK) exposes CTRL, RELOAD, COUNT and STATUS.
// A prescaler produces counter ticks; count expiry raises a level interrupt.
module limn2600_bus_timer #(
  parameter int PRESCALE = 4,
  parameter int CNT_W    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        rdy,
  output logic        irq
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_RELOAD = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  typedef enum logic {
    ST_IDLE,
    ST_ACK
  } state_e;

  state_e             state_q, state_d;
  logic               rdy_q, rdy_d;
  logic [31:0]        data_out_q, data_out_d;
  logic               en_q, en_d;
  logic               ie_q, ie_d;
  logic               ar_q, ar_d;
  logic [CNT_W-1:0]   reload_q, reload_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               pending_q, pending_d;
  logic [PW-1:0]      presc_q, presc_d;

  logic               accept;
  logic [1:0]         reg_sel;
  logic               wr_ctrl, wr_reload, wr_count, wr_status;
  logic [31:0]        rd_data;
  logic               tick;
  logic               count_tick;
  logic               expire;
  logic               unused_bits;

  // Only addr[3:2] selects a register; the remaining address bits are don't-care.
  assign unused_bits = ^{addr[31:4], addr[1:0], data_in};

  assign accept    = (state_q == ST_IDLE) && cs;
  assign reg_sel   = addr[3:2];
  assign wr_ctrl   = accept && we && (reg_sel == REG_CTRL);
  assign wr_reload = accept && we && (reg_sel == REG_RELOAD);
  assign wr_count  = accept && we && (reg_sel == REG_COUNT);
  assign wr_status = accept && we && (reg_sel == REG_STATUS);

  // Read mux over the register values as they stand before the accepting edge.
  always_comb begin
    rd_data = 32'd0;
    case (reg_sel)
      REG_CTRL:   rd_data = {29'd0, ar_q, ie_q, en_q};
      REG_RELOAD: rd_data = 32'(reload_q);
      REG_COUNT:  rd_data = 32'(count_q);
      REG_STATUS: rd_data = {31'd0, pending_q};
      default:    rd_data = 32'd0;
    endcase
  end

  // Bus FSM: accept in IDLE, present rdy and read data for exactly one cycle in ACK.
  always_comb begin
    state_d    = state_q;
    rdy_d      = 1'b0;
    data_out_d = 32'd0;
    case (state_q)
      ST_IDLE: begin
        if (cs) begin
          state_d    = ST_ACK;
          rdy_d      = 1'b1;
          data_out_d = we ? 32'd0 : rd_data;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // A tick fires when the enabled prescaler wraps; a COUNT write on that edge swallows it.
  assign tick       = en_q && (presc_q == PRESC_MAX);
  assign count_tick = tick && !wr_count;
  assign expire     = count_tick && (count_q == '0);

  // Timer datapath: prescaler, counter, control bits and pending flag with race priorities.
  always_comb begin
    en_d      = en_q;
    ie_d      = ie_q;
    ar_d      = ar_q;
    reload_d  = reload_q;
    count_d   = count_q;
    pending_d = pending_q;
    presc_d   = presc_q;

    if (count_tick) begin
      if (count_q != '0) begin
        count_d = count_q - CNT_W'(1);
      end else if (ar_q) begin
        count_d = reload_q;
      end else begin
        en_d = 1'b0;
      end
    end
    if (wr_count) begin
      count_d = data_in[CNT_W-1:0];
    end

    if (wr_ctrl) begin
      en_d = data_in[0];
      ie_d = data_in[1];
      ar_d = data_in[2];
    end

    if (wr_reload) begin
      reload_d = data_in[CNT_W-1:0];
    end

    if (wr_status && data_in[0]) begin
      pending_d = 1'b0;
    end
    if (expire) begin
      pending_d = 1'b1;
    end

    if (en_q && en_d && !tick) begin
      presc_d = presc_q + PW'(1);
    end else begin
      presc_d = '0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      rdy_q      <= 1'b0;
      data_out_q <= 32'd0;
      en_q       <= 1'b0;
      ie_q       <= 1'b0;
      ar_q       <= 1'b0;
      reload_q   <= '0;
      count_q    <= '0;
      pending_q  <= 1'b0;
      presc_q    <= '0;
    end else begin
      state_q    <= state_d;
      rdy_q      <= rdy_d;
      data_out_q <= data_out_d;
      en_q       <= en_d;
      ie_q       <= ie_d;
      ar_q       <= ar_d;
      reload_q   <= reload_d;
      count_q    <= count_d;
      pending_q  <= pending_d;
      presc_q    <= presc_d;
    end
  end

  assign rdy      = rdy_q;
  assign data_out = data_out_q;
  assign irq      = pending_q & ie_q;

endmodule

// File: tb/tb_limn2600_bus_timer.sv
// tb_limn2600_bus_timer: directed bench for limn2600_bus_timer with a cycle-level
// behavioural model (tick derived from cycles since enable) and literal spot checks.
module tb_limn2600_bus_timer;

  localparam int P = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cs = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] data_in = 32'd0;
  logic [31:0] data_out;
  logic        rdy;
  logic        irq;

  int assertions = 0;
  int failures = 0;
  int edges = 0;
  logic chk_on = 1'b0;

  limn2600_bus_timer #(.PRESCALE(P), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .cs(cs), .we(we), .addr(addr), .data_in(data_in),
    .data_out(data_out), .rdy(rdy), .irq(irq)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Edge counter used to time events relative to an acceptance edge
  always @(posedge clk) edges++;

  // Watchdog so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_ack, m_en, m_ie, m_ar, m_pending;
  logic [31:0] m_reload, m_count, m_data;
  int          m_age;
  logic        m_acc, m_tick, m_expire, m_cwr, m_old_en, m_old_ar;
  logic [31:0] m_old_reload;

  function automatic logic [31:0] modelRead(input logic [1:0] r);
    case (r)
      2'd0:    return {29'd0, m_ar, m_ie, m_en};
      2'd1:    return m_reload;
      2'd2:    return m_count;
      default: return {31'd0, m_pending};
    endcase
  endfunction

  // Model update: evaluates one clock edge from the bus inputs and the timer rules
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ack = 0; m_en = 0; m_ie = 0; m_ar = 0; m_pending = 0;
      m_reload = 0; m_count = 0; m_data = 0; m_age = 0;
    end else begin
      m_acc = !m_ack && cs;
      m_data = (m_acc && !we) ? modelRead(addr[3:2]) : 32'd0;
      m_old_en = m_en;
      m_old_ar = m_ar;
      m_old_reload = m_reload;
      m_tick = 1'b0;
      if (m_en) begin
        m_age++;
        m_tick = ((m_age % P) == 0);
      end
      m_cwr = m_acc && we && (addr[3:2] == 2'd2);
      m_expire = 1'b0;
      if (m_tick && !m_cwr) begin
        if (m_count != 0) m_count = m_count - 1;
        else begin
          m_expire = 1'b1;
          if (m_old_ar) m_count = m_old_reload;
          else m_en = 1'b0;
        end
      end
      if (m_acc && we) begin
        case (addr[3:2])
          2'd0: begin
            m_en = data_in[0]; m_ie = data_in[1]; m_ar = data_in[2];
            if (!m_old_en && data_in[0]) m_age = 0;
          end
          2'd1: m_reload = data_in;
          2'd2: m_count = data_in;
          default: if (data_in[0]) m_pending = 1'b0;
        endcase
      end
      if (m_expire) m_pending = 1'b1;
      m_ack = m_acc;
    end
  end

  // Compare process: DUT outputs against the model on every falling edge
  always @(negedge clk) begin
    if (chk_on) begin
      checkOutput("model_rdy", 32'(rdy), 32'(m_ack));
      checkOutput("model_data_out", data_out, m_data);
      checkOutput("model_irq", 32'(irq), 32'(m_pending & m_ie));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic applyStimulus(input logic w, input logic [1:0] r, input logic [31:0] d,
                               output logic [31:0] q);
    int n;
    logic [31:0] a;
    a = $urandom();
    a[3:2] = r;
    cs = 1'b1; we = w; addr = a; data_in = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rdy !== 1'b1 && n < 4);
    if (rdy !== 1'b1) checkOutput("rdy_timeout", 32'(rdy), 32'd1);
    q = data_out;
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic busWrite(input logic [1:0] r, input logic [31:0] d);
    logic [31:0] q;
    applyStimulus(1'b1, r, d, q);
  endtask

  task automatic busRead(input string name, input logic [1:0] r, input logic [31:0] exp);
    logic [31:0] q;
    applyStimulus(1'b0, r, 32'hDEAD_BEEF, q);
    checkOutput(name, q, exp);
  endtask

  task automatic waitUntilEdge(input int t);
    while (edges < t) @(negedge clk);
  endtask

  task automatic pollIrq(output int at);
    int n;
    n = 0;
    while (irq !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (irq !== 1'b1) checkOutput("irq_timeout", 32'(irq), 32'd1);
    at = edges;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int e0;
    int at;

    // Reset state
    #12;
    checkOutput("reset_rdy", 32'(rdy), 32'd0);
    checkOutput("reset_data_out", data_out, 32'd0);
    checkOutput("reset_irq", 32'(irq), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    chk_on = 1'b1;
    @(negedge clk);

    // Handshake with cs held high: write RELOAD then read it back
    cs = 1'b1; we = 1'b1; addr = 32'h0000_0004; data_in = 32'h1234;
    @(negedge clk);
    checkOutput("hs_write_rdy", 32'(rdy), 32'd1);
    checkOutput("hs_write_data", data_out, 32'd0);
    we = 1'b0;
    @(negedge clk);
    checkOutput("hs_gap_rdy", 32'(rdy), 32'd0);
    checkOutput("hs_gap_data", data_out, 32'd0);
    @(negedge clk);
    checkOutput("hs_read_rdy", 32'(rdy), 32'd1);
    checkOutput("hs_read_data", data_out, 32'h0000_1234);
    cs = 1'b0;
    @(negedge clk);
    checkOutput("hs_after_rdy", 32'(rdy), 32'd0);

    // Auto-reload period
    busWrite(2'd1, 32'd3);
    busWrite(2'd2, 32'd3);
    busWrite(2'd0, 32'h7);
    e0 = edges;
    pollIrq(at);
    checkOutput("ar_first_expiry", 32'(at - e0), 32'd16);
    busWrite(2'd3, 32'd1);
    waitUntilEdge(e0 + 18);
    busRead("ar_count_3", 2'd2, 32'd3);
    waitUntilEdge(e0 + 22);
    busRead("ar_count_2", 2'd2, 32'd2);
    waitUntilEdge(e0 + 26);
    busRead("ar_count_1", 2'd2, 32'd1);
    waitUntilEdge(e0 + 30);
    busRead("ar_count_0", 2'd2, 32'd0);
    pollIrq(at);
    checkOutput("ar_second_expiry", 32'(at - e0), 32'd32);

    // Reset asserted in the middle of an access, with irq high
    @(negedge clk);
    cs = 1'b1; we = 1'b0; addr = 32'h0000_0004;
    @(posedge clk);
    #1;
    checkOutput("mid_rdy_before", 32'(rdy), 32'd1);
    checkOutput("mid_data_before", data_out, 32'd3);
    rst = 1'b0;
    #1;
    checkOutput("mid_rdy_reset", 32'(rdy), 32'd0);
    checkOutput("mid_data_reset", data_out, 32'd0);
    checkOutput("mid_irq_reset", 32'(irq), 32'd0);
    cs = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    busRead("post_reset_ctrl", 2'd0, 32'd0);
    busRead("post_reset_reload", 2'd1, 32'd0);
    busRead("post_reset_count", 2'd2, 32'd0);
    busRead("post_reset_status", 2'd3, 32'd0);

    // One-shot
    busWrite(2'd1, 32'd5);
    busWrite(2'd2, 32'd2);
    busWrite(2'd0, 32'h3);
    e0 = edges;
    pollIrq(at);
    checkOutput("os_expiry", 32'(at - e0), 32'd12);
    busRead("os_ctrl", 2'd0, 32'h2);
    busRead("os_count", 2'd2, 32'd0);
    waitUntilEdge(e0 + 40);
    busRead("os_count_later", 2'd2, 32'd0);
    busRead("os_status", 2'd3, 32'd1);
    busWrite(2'd3, 32'd1);

    // Clear racing an expiry, plain clear, and masking
    busWrite(2'd1, 32'd3);
    busWrite(2'd2, 32'd0);
    busWrite(2'd0, 32'h7);
    e0 = edges;
    waitUntilEdge(e0 + 3);
    busWrite(2'd3, 32'd1);
    checkOutput("race_clear_irq", 32'(irq), 32'd1);
    busRead("race_clear_status", 2'd3, 32'd1);
    busWrite(2'd3, 32'd1);
    checkOutput("clear_irq", 32'(irq), 32'd0);
    busWrite(2'd0, 32'h5);
    waitUntilEdge(e0 + 24);
    busRead("mask_status", 2'd3, 32'd1);
    checkOutput("mask_irq", 32'(irq), 32'd0);
    busWrite(2'd0, 32'h0);
    busWrite(2'd3, 32'd1);

    // COUNT write on a tick edge
    busWrite(2'd2, 32'd5);
    busWrite(2'd0, 32'h1);
    e0 = edges;
    waitUntilEdge(e0 + 7);
    busWrite(2'd2, 32'd7);
    busRead("wrace_count_a", 2'd2, 32'd7);
    busRead("wrace_count_b", 2'd2, 32'd7);
    busRead("wrace_count_c", 2'd2, 32'd6);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
